// File: rtl/parameterized_updown_modulo_counter_if.sv
// Handshake bundle for the up/down modulo counter.
// Master drives control/data (clear, load, data_in, enable, up_dn,
// step, limit, clear_flags); slave returns count, tc, flags and
// the at_limit/at_zero compares.
interface parameterized_updown_modulo_counter_if #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
);
    logic                  clear;
    logic                  load;
    logic [WIDTH-1:0]      data_in;
    logic                  enable;
    logic                  up_dn;
    logic [STEP_WIDTH-1:0] step;
    logic [WIDTH-1:0]      limit;
    logic                  clear_flags;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  ovf_flag;
    logic                  unf_flag;
    logic                  at_limit;
    logic                  at_zero;

    modport master (
        output clear, load, data_in, enable, up_dn,
        output step, limit, clear_flags,
        input  count, tc, ovf_flag, unf_flag,
        input  at_limit, at_zero
    );

    modport slave (
        input  clear, load, data_in, enable, up_dn,
        input  step, limit, clear_flags,
        output count, tc, ovf_flag, unf_flag,
        output at_limit, at_zero
    );
endinterface

// File: rtl/parameterized_updown_modulo_counter.sv
// Loadable up/down counter, programmable step and modulo limit,
// wrap or saturate build. Ports: clk, rst_n (async active-low),
// bus (slave modport: controls in, count/tc/flags/compares out).
module parameterized_updown_modulo_counter #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic clk,
    input  logic rst_n,
    parameterized_updown_modulo_counter_if.slave bus
);
    localparam int W1 = WIDTH + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [W1-1:0] w_cnt;
    logic [W1-1:0] w_lim;
    logic [W1-1:0] w_lim_p1;
    logic [W1-1:0] w_step;
    logic [W1-1:0] w_s;
    logic [W1-1:0] w_din;
    logic [W1-1:0] w_load;
    logic [W1-1:0] w_sum;
    logic [W1-1:0] w_up_wrap;
    logic [W1-1:0] w_dn;
    logic [W1-1:0] w_dn_wrap;
    logic [W1-1:0] w_nxt;
    logic          w_ev_up;
    logic          w_ev_dn;
    logic          w_unused;

    // Everything is widened by one bit so sums never wrap.
    assign w_cnt    = {1'b0, r_count};
    assign w_lim    = {1'b0, bus.limit};
    assign w_din    = {1'b0, bus.data_in};
    assign w_lim_p1 = w_lim + {{WIDTH{1'b0}}, 1'b1};
    assign w_step   = {{(W1-STEP_WIDTH){1'b0}}, bus.step};

    assign w_s    = (w_step > w_lim) ? w_lim : w_step;
    assign w_load = (w_din > w_lim) ? w_lim : w_din;

    assign w_sum     = w_cnt + w_s;
    assign w_up_wrap = w_sum - w_lim_p1;
    assign w_dn      = w_cnt - w_s;
    assign w_dn_wrap = w_cnt + w_lim_p1 - w_s;

    always_comb begin
        w_nxt   = w_cnt;
        w_ev_up = 1'b0;
        w_ev_dn = 1'b0;
        if (bus.load) begin
            w_nxt = w_load;
        end else if (bus.enable) begin
            if (w_cnt > w_lim) begin
                // Limit was lowered under the count: pull back in range.
                w_nxt   = (SATURATE != 0) ? w_lim : '0;
                w_ev_up = 1'b1;
            end else if (w_s == '0) begin
                w_nxt = w_cnt;
            end else if (bus.up_dn) begin
                if (w_sum > w_lim) begin
                    w_nxt   = (SATURATE != 0) ? w_lim : w_up_wrap;
                    w_ev_up = 1'b1;
                end else begin
                    w_nxt = w_sum;
                end
            end else begin
                if (w_cnt < w_s) begin
                    w_nxt   = (SATURATE != 0) ? '0 : w_dn_wrap;
                    w_ev_dn = 1'b1;
                end else begin
                    w_nxt = w_dn;
                end
            end
        end
    end

    // The top bit of w_nxt is always zero once the range is resolved.
    assign w_unused = w_nxt[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (bus.clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_nxt[WIDTH-1:0];
            r_tc    <= w_ev_up | w_ev_dn;
            // A flag set on this edge beats clear_flags.
            r_ovf   <= w_ev_up | (r_ovf & ~bus.clear_flags);
            r_unf   <= w_ev_dn | (r_unf & ~bus.clear_flags);
        end
    end

    assign bus.count    = r_count;
    assign bus.tc       = r_tc;
    assign bus.ovf_flag = r_ovf;
    assign bus.unf_flag = r_unf;
    assign bus.at_limit = (r_count == bus.limit);
    assign bus.at_zero  = (r_count == '0);
endmodule
